lru_state_table: RTL and testbench

//  Per-set storage for the 8-way rank-based LRU state (rank 3'b111 = MRU, 3'b000 = LRU).

---
 rtl/lru_pkg.sv | 19 +
 rtl/lru_state_table_perm_check.sv | 19 +
 rtl/lru_state_table.sv | 146 ++++++++++++++
 tb/tb_lru_state_table.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared constants, types and helpers for the rank-based 8-way LRU state table.
package lru_pkg;
    localparam int LRU_WAYS = 8;
    localparam int RANK_W   = 3;

    typedef logic [RANK_W-1:0] rank_t;

    localparam rank_t RANK_MRU = 3'b111;
    localparam rank_t RANK_LRU = 3'b000;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic rank_t init_rank(input int way);
        return rank_t'(way);
    endfunction
endpackage

// File: rtl/lru_state_table_perm_check.sv
// Combinational check that eight 3-bit ranks form a permutation of 0..7.
module lru_perm_check
    import lru_pkg::*;
(
    input  rank_t [LRU_WAYS-1:0] ranks,
    output logic                 is_perm
);
    logic [LRU_WAYS-1:0] seen;

    // Eight values cover all eight codes exactly when they are all distinct.
    always_comb begin
        seen = '0;
        for (int w = 0; w < LRU_WAYS; w++) begin
            seen[ranks[w]] = 1'b1;
        end
    end

    assign is_perm = &seen;
endmodule

// File: rtl/lru_state_table.sv
// Per-set LRU rank storage: init sweep, two-stage lookup pipeline,
// write-back of calculator results, victim report and permutation check.
module lru_state_table
    import lru_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [IDX_W-1:0]  i_set_idx,
    input  logic              i_hit_sig,
    input  logic [7:0]        i_hit_way_8,
    input  logic              i_update,
    output logic [RANK_W-1:0] o_lru_buffer0,
    output logic [RANK_W-1:0] o_lru_buffer1,
    output logic [RANK_W-1:0] o_lru_buffer2,
    output logic [RANK_W-1:0] o_lru_buffer3,
    output logic [RANK_W-1:0] o_lru_buffer4,
    output logic [RANK_W-1:0] o_lru_buffer5,
    output logic [RANK_W-1:0] o_lru_buffer6,
    output logic [RANK_W-1:0] o_lru_buffer7,
    output logic              o_hit_sig,
    output logic [7:0]        o_hit_way_8,
    input  logic [7:0]        i_lru_flag,
    input  logic [RANK_W-1:0] i_lru_datain0,
    input  logic [RANK_W-1:0] i_lru_datain1,
    input  logic [RANK_W-1:0] i_lru_datain2,
    input  logic [RANK_W-1:0] i_lru_datain3,
    input  logic [RANK_W-1:0] i_lru_datain4,
    input  logic [RANK_W-1:0] i_lru_datain5,
    input  logic [RANK_W-1:0] i_lru_datain6,
    input  logic [RANK_W-1:0] i_lru_datain7,
    output logic              o_resp_valid,
    output logic [7:0]        o_victim_way_8,
    output logic              o_err,
    output logic              o_perm_err
);
    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic                 s1_valid;
    logic                 s1_hit_sig;
    logic                 s1_update;
    logic [IDX_W-1:0]     s1_idx;
    logic [7:0]           s1_hit_way;
    rank_t [LRU_WAYS-1:0] mem [SETS];
    rank_t [LRU_WAYS-1:0] rd_ranks;
    rank_t [LRU_WAYS-1:0] wr_ranks;
    logic                 accept;
    logic                 s1_onehot;
    logic                 s1_err;
    logic                 wr_en;
    logic                 is_perm;

    // Ready drops in the flush cycle so no request enters behind the sweep.
    assign o_req_ready = (state == ST_RUN) && !i_flush;
    assign accept      = i_req_valid && o_req_ready;

    assign rd_ranks = s1_valid ? mem[s1_idx] : '0;
    assign wr_ranks = {i_lru_datain7, i_lru_datain6,
                       i_lru_datain5, i_lru_datain4,
                       i_lru_datain3, i_lru_datain2,
                       i_lru_datain1, i_lru_datain0};

    assign s1_onehot = (s1_hit_way != 8'd0) &&
                       ((s1_hit_way & (s1_hit_way - 8'd1)) == 8'd0);
    assign s1_err    = s1_hit_sig && !s1_onehot;
    assign wr_en     = s1_valid && s1_update && !s1_err;

    assign o_lru_buffer0 = rd_ranks[0];
    assign o_lru_buffer1 = rd_ranks[1];
    assign o_lru_buffer2 = rd_ranks[2];
    assign o_lru_buffer3 = rd_ranks[3];
    assign o_lru_buffer4 = rd_ranks[4];
    assign o_lru_buffer5 = rd_ranks[5];
    assign o_lru_buffer6 = rd_ranks[6];
    assign o_lru_buffer7 = rd_ranks[7];
    assign o_hit_sig     = s1_hit_sig;
    assign o_hit_way_8   = s1_hit_way;

    lru_perm_check u_perm (
        .ranks   (rd_ranks),
        .is_perm (is_perm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            ptr        <= '0;
            s1_valid   <= 1'b0;
            s1_hit_sig <= 1'b0;
            s1_update  <= 1'b0;
            s1_idx     <= '0;
            s1_hit_way <= '0;
        end else begin
            if (i_flush) begin
                state <= ST_INIT;
                ptr   <= '0;
            end else if (state == ST_INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == IDX_W'(SETS - 1)) begin
                    state <= ST_RUN;
                end
            end
            s1_valid   <= accept;
            s1_hit_sig <= accept && i_hit_sig;
            s1_update  <= accept && i_update;
            s1_hit_way <= accept ? i_hit_way_8 : 8'd0;
            if (accept) begin
                s1_idx <= i_set_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_resp_valid   <= 1'b0;
            o_victim_way_8 <= '0;
            o_err          <= 1'b0;
            o_perm_err     <= 1'b0;
        end else begin
            o_resp_valid   <= s1_valid;
            o_victim_way_8 <= s1_valid ? i_lru_flag : 8'd0;
            o_err          <= s1_valid && s1_err;
            if (s1_valid && !is_perm) begin
                o_perm_err <= 1'b1;
            end
        end
    end

    // Storage has no reset: the sweep after reset defines every set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                for (int w = 0; w < LRU_WAYS; w++) begin
                    mem[ptr][w] <= init_rank(w);
                end
            end else if (wr_en) begin
                mem[s1_idx] <= wr_ranks;
            end
        end
    end
endmodule

// File: tb/tb_lru_state_table.sv
// Bench for lru_state_table: stub rank calculator, order-list LRU model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_lru_state_table;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] set_idx = '0;
    logic       hit_sig = 1'b0;
    logic [7:0] hit_way = '0;
    logic       update = 1'b0;
    logic [2:0] lb [8];
    logic       s1_hit;
    logic [7:0] s1_way;
    logic [7:0] lru_flag;
    logic [2:0] nxt [8];
    logic       resp_valid;
    logic [7:0] victim;
    logic       err;
    logic       perm_err;
    bit         force_dup = 1'b0;
    int         calc_tgt;

    always #5 clk = ~clk;

    lru_state_table dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_set_idx      (set_idx),
        .i_hit_sig      (hit_sig),
        .i_hit_way_8    (hit_way),
        .i_update       (update),
        .o_lru_buffer0  (lb[0]),
        .o_lru_buffer1  (lb[1]),
        .o_lru_buffer2  (lb[2]),
        .o_lru_buffer3  (lb[3]),
        .o_lru_buffer4  (lb[4]),
        .o_lru_buffer5  (lb[5]),
        .o_lru_buffer6  (lb[6]),
        .o_lru_buffer7  (lb[7]),
        .o_hit_sig      (s1_hit),
        .o_hit_way_8    (s1_way),
        .i_lru_flag     (lru_flag),
        .i_lru_datain0  (nxt[0]),
        .i_lru_datain1  (nxt[1]),
        .i_lru_datain2  (nxt[2]),
        .i_lru_datain3  (nxt[3]),
        .i_lru_datain4  (nxt[4]),
        .i_lru_datain5  (nxt[5]),
        .i_lru_datain6  (nxt[6]),
        .i_lru_datain7  (nxt[7]),
        .o_resp_valid   (resp_valid),
        .o_victim_way_8 (victim),
        .o_err          (err),
        .o_perm_err     (perm_err)
    );

    // Stub calculator: promote the target to MRU, age the ranks above it.
    always_comb begin
        lru_flag = '0;
        calc_tgt = 0;
        for (int w = 7; w >= 0; w--) begin
            if (lb[w] == 3'd0) begin
                lru_flag = 8'd1 << w;
                if (!s1_hit) calc_tgt = w;
            end
            if (s1_hit && s1_way[w]) calc_tgt = w;
        end
        for (int w = 0; w < 8; w++) begin
            nxt[w] = (lb[w] > lb[calc_tgt]) ? lb[w] - 3'd1 : lb[w];
        end
        nxt[calc_tgt] = 3'd7;
        if (force_dup) begin
            for (int w = 0; w < 8; w++) nxt[w] = 3'd0;
        end
    end

    typedef struct {
        int          due;
        logic [23:0] ranks;
        logic [7:0]  vict;
        bit          err;
        bit          bad;
    } exp_t;

    exp_t s1_q[$];
    exp_t rsp_q[$];
    int   ord [64][8];
    bit   dup [64];
    bit   exp_perm = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    endfunction

    function automatic logic [23:0] buf_bits();
        return {lb[7], lb[6], lb[5], lb[4], lb[3], lb[2], lb[1], lb[0]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            for (int k = 0; k < 8; k++) ord[s][k] = k;
            dup[s] = 1'b0;
        end
    endtask

    // ord[s][0] is the LRU way, ord[s][7] the MRU way; rank = list position.
    task automatic model_accept(input int idx, input bit hit,
                                input logic [7:0] way, input bit upd);
        exp_t e;
        int   tgt;
        int   pos;
        e.due   = cyc + 1;
        e.ranks = '0;
        if (dup[idx]) begin
            e.vict = 8'h01;
            e.bad  = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) e.ranks[ord[idx][k]*3 +: 3] = 3'(k);
            e.vict = 8'h01 << ord[idx][0];
            e.bad  = 1'b0;
        end
        e.err = hit && ($countones(way) != 1);
        if (upd && !e.err) begin
            if (force_dup) begin
                dup[idx] = 1'b1;
            end else begin
                tgt = ord[idx][0];
                if (hit) for (int w = 0; w < 8; w++) if (way[w]) tgt = w;
                pos = 0;
                for (int k = 0; k < 8; k++) if (ord[idx][k] == tgt) pos = k;
                for (int k = pos; k < 7; k++) ord[idx][k] = ord[idx][k+1];
                ord[idx][7] = tgt;
            end
        end
        s1_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                s1_q.delete();
                rsp_q.delete();
                exp_perm = 1'b0;
            end else begin
                if (s1_q.size() > 0 && s1_q[0].due == cyc) begin
                    e = s1_q.pop_front();
                    chk("s1_ranks", 32'(buf_bits()), 32'(e.ranks));
                    e.due = cyc + 1;
                    rsp_q.push_back(e);
                end
                if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                    e = rsp_q.pop_front();
                    if (e.bad) exp_perm = 1'b1;
                    chk("resp_valid", 32'(resp_valid), 32'd1);
                    chk("victim", 32'(victim), 32'(e.vict));
                    chk("err", 32'(err), 32'(e.err));
                end else begin
                    chk("resp_idle", 32'(resp_valid), 32'd0);
                end
                chk("perm_err", 32'(perm_err), 32'(exp_perm));
            end
        end
    end

    // Inputs change 2 time units after the edge; each call spans one cycle.
    task automatic drive(input bit v, input int idx, input bit hit,
                         input logic [7:0] way, input bit upd, input bit fl);
        req_valid = v;
        set_idx   = 6'(idx);
        hit_sig   = hit;
        hit_way   = way;
        update    = upd;
        flush     = fl;
        #1;
        if (fl) chk("ready_on_flush", 32'(req_ready), 32'd0);
        if (v && req_ready) model_accept(idx, hit, way, upd);
        if (fl) model_reset();
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_victim", 32'(victim), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_perm", 32'(perm_err), 32'd0);
        chk("rst_buf", 32'(buf_bits()), 32'd0);
        rst = 1'b0;
        wait_ready(n);
        chk("init_cycles", 32'(n), 32'd64);

        // Identity lookup on set 5.
        drive(1'b1, 5, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_ranks", 32'(buf_bits()), 32'hFAC688);
        idle();
        chk("t1_victim", 32'(victim), 32'h01);

        // Hit way 2 on set 3, then lookup.
        drive(1'b1, 3, 1'b1, 8'h04, 1'b1, 1'b0);
        drive(1'b1, 3, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_ranks", 32'(buf_bits()), 32'hD635C8);
        idle();
        chk("t2_victim", 32'(victim), 32'h01);

        // Four back-to-back misses on set 0.
        drive(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_victim0", 32'(victim), 32'h01);
        drive(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_victim1", 32'(victim), 32'h02);
        drive(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_victim2", 32'(victim), 32'h04);
        idle();
        chk("t3_victim3", 32'(victim), 32'h08);

        // Bad hit vector on set 7: error, no write.
        drive(1'b1, 7, 1'b1, 8'h06, 1'b1, 1'b0);
        drive(1'b1, 7, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_victim", 32'(victim), 32'h01);
        chk("t4_ranks", 32'(buf_bits()), 32'hFAC688);
        idle();
        drive(1'b1, 7, 1'b1, 8'h00, 1'b1, 1'b0);
        idle();
        chk("t4_err_zero", 32'(err), 32'd1);

        // Flush alongside a request while another sits in S1.
        drive(1'b1, 9, 1'b1, 8'h80, 1'b1, 1'b0);
        drive(1'b1, 4, 1'b1, 8'h01, 1'b1, 1'b1);
        chk("t5_s1_resp", 32'(resp_valid), 32'd1);
        wait_ready(n);
        chk("flush_cycles", 32'(n), 32'd64);
        for (int s = 0; s < 64; s++) drive(1'b1, s, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_last_ranks", 32'(buf_bits()), 32'hFAC688);
        idle();
        idle();

        // Calculator returns duplicate ranks for set 10.
        force_dup = 1'b1;
        drive(1'b1, 10, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        force_dup = 1'b0;
        drive(1'b1, 10, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_dup_ranks", 32'(buf_bits()), 32'h000000);
        idle();
        chk("t6_perm_err", 32'(perm_err), 32'd1);
        drive(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_ready(n);
        chk("t6_flush_cycles", 32'(n), 32'd64);
        chk("t6_perm_sticky", 32'(perm_err), 32'd1);
        idle();

        chk("queues_drained", 32'(s1_q.size() + rsp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
